// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: RAM handshake states, data word, and arbiter state/grant encodings.
// Arbiter types live here so that benches can probe the arbiter's internal state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
// Count is visible one cycle after inc; there is no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Icache/dcache to single-port RAM arbiter: one IDLE arbitration cycle, then live pass-through until ACCESS.
// A client is stalled on its wait line until the RAM reports ACCESS; ties alternate between the clients.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  word_t            iaddr,
    output logic             iwait,
    output word_t            iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  word_t            daddr,
    input  word_t            dstore,
    output logic             dwait,
    output word_t            dload,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate,
    output logic             ram_err,
    output logic [CNT_W-1:0] dacc_cnt,
    output logic [CNT_W-1:0] iacc_cnt
);

    arb_state_t state, nxt_state;
    grant_t     last_grant, nxt_grant;
    logic       dreq;
    logic       d_done, i_done;
    logic       err_set;

    assign dreq = dREN | dWEN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            ram_err    <= 1'b0;
        end else begin
            state      <= nxt_state;
            last_grant <= nxt_grant;
            if (err_set) begin
                ram_err <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_grant = last_grant;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        iload     = '0;
        dwait     = 1'b1;
        dload     = '0;
        d_done    = 1'b0;
        i_done    = 1'b0;
        err_set   = 1'b0;

        unique case (state)
            IDLE: begin
                // On a tie the client that did not win last time goes first.
                if (dreq && (!iREN || last_grant == GRANT_I)) begin
                    nxt_state = DSERV;
                    nxt_grant = GRANT_D;
                end else if (iREN) begin
                    nxt_state = ISERV;
                    nxt_grant = GRANT_I;
                end
            end
            DSERV: begin
                if (!dreq) begin
                    nxt_state = IDLE;
                end else begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait     = 1'b0;
                        dload     = ramload;
                        d_done    = 1'b1;
                        nxt_state = IDLE;
                    end else if (ramstate == ERROR) begin
                        err_set = 1'b1;
                    end
                end
            end
            ISERV: begin
                if (!iREN) begin
                    nxt_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait     = 1'b0;
                        iload     = ramload;
                        i_done    = 1'b1;
                        nxt_state = IDLE;
                    end else if (ramstate == ERROR) begin
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_dcnt (
        .CLK (CLK),
        .RST (RST),
        .inc (d_done),
        .cnt (dacc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_icnt (
        .CLK (CLK),
        .RST (RST),
        .inc (i_done),
        .cnt (iacc_cnt)
    );

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Memory-side responder for the cache bus. Sits between the icache and dcache initiators and the single-ported RAM. Grants one client at a time, forwards its read or write to the RAM, and holds that client's wait line high until the RAM reports ACCESS. It also keeps saturating per-client completion counters and a sticky RAM error flag.

## Interface
Parameters:
- CNT_W, default 32: width of the completion counters.

Ports (clock and reset first):
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  0 only in the cycle the icache read completes.
- iload  out  32  icache read data; valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request. dREN and dWEN are never both 1.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  0 only in the cycle the dcache access completes.
- dload  out  32  dcache read data; valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ram_err  out  1  sticky; set on any ramstate==ERROR while a client is being served.
- dacc_cnt  out  CNT_W  count of completed dcache accesses, saturating.
- iacc_cnt  out  CNT_W  count of completed icache accesses, saturating.

## Operation
- FSM states: IDLE, DSERV, ISERV. Register last_grant (D or I).
- IDLE:
  - No RAM enables.
  - Both clients pending (dREN|dWEN and iREN): grant the client not equal to last_grant.
  - Only one pending: grant it.
  - On grant, go to DSERV/ISERV and update last_grant.
  - Nothing pending: stay in IDLE.
- DSERV:
  - ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN; all driven live from the dcache lines.
  - ramstate==ACCESS: dwait=0, dload=ramload, dacc_cnt increments, go to IDLE.
  - BUSY, FREE or ERROR: dwait=1, stay. ERROR also sets ram_err.
  - Abort: dREN=dWEN=0 while in DSERV. No RAM enables that cycle, dwait=1, no count, go to IDLE.
- ISERV: mirror of DSERV using iaddr/iREN. ramWEN is always 0 and ramstore is 0.
- The non-granted client's wait line stays 1 and its load output is 0.
- Counters saturate at 2^CNT_W-1. They never wrap.
- ram_err clears only on reset.

## Timing
- Reset values:
  - state=IDLE, last_grant=I, so D wins the first tie.
  - iwait=dwait=1; iload=dload=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
  - ram_err=0; both counters 0.
- Latency: a request sampled at edge t enters the serve state at t+1. The RAM enable is high from t+1. The completion cycle is the first cycle at or after t+1 with ramstate==ACCESS.
  - Minimum request-to-completion is 2 cycles: one IDLE cycle plus one ACCESS cycle.
  - The wait line drops combinationally in the ACCESS cycle.
- A client holding its request after completion is re-arbitrated in the following IDLE cycle. Back-to-back words from one client therefore cost at least 2 cycles each.
- A dcache two-word burst (WB0/WB1, MEM0/MEM1) can be interleaved with an icache access between its words. The burst is not locked.
- The address/data/enable seen by the RAM follows the live client signals. The client holds them stable until its wait line is 0.
- Asserting RST mid-service drops the RAM enables immediately (asynchronous) and returns to IDLE. No completion is signalled.

## Structure
- ramstate_t and word_t come from cpu_types_pkg (existing).
- Add arb_state_t (IDLE, DSERV, ISERV) and grant_t (GRANT_I, GRANT_D) to cpu_types_pkg so benches can probe them.
- One sub-module, sat_counter (parameter W, inputs inc and RST), instantiated twice for the counters.
- Everything else is a single always_ff for state/last_grant/ram_err and a single always_comb for outputs and next state.

## Test plan
- Reset, then idle with no requests: iwait=dwait=1, ramREN=ramWEN=0, counters 0, state stays IDLE.
- dREN, daddr=0x40, RAM gives BUSY×2 then ACCESS with ramload=0xDEADBEEF:
  - dwait=0 and dload=0xDEADBEEF in cycle 4 after the request.
  - dacc_cnt=1, then IDLE.
- dWEN, daddr=0x3100, dstore=0x12; iREN, iaddr=0x0 in the same cycle; RAM ACCESS every cycle:
  - D is served first (ramWEN=1, ramstore=0x12), then I.
  - With both still requesting, grants alternate D, I, D.
- dREN dropped after 1 BUSY cycle in DSERV: RAM enables fall, no dwait pulse, dacc_cnt unchanged, then serve pending iREN.
- ramstate=ERROR during ISERV, then ACCESS: ram_err=1 and stays 1 after completion; iacc_cnt=1.
- CNT_W=3, eight dcache completions: dacc_cnt reaches 7 and holds.
  - Separately, assert RST mid-DSERV: outputs return to reset values asynchronously.
